// File: rtl/rot_nibble_packer.sv
// Packs 4-bit rotator results into NIBBLES-wide words behind a
// 2-entry valid/ready output buffer, with flush of partial words.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid, in, flush   upstream nibble + flush request
//   in_ready              can take a nibble/flush this cycle
//   out_valid, out        head word of the output buffer
//   out_cnt               valid nibbles in out (0 when empty)
//   out_ready             downstream takes the head word
module rot_nibble_packer #(
   parameter int NIBBLES = 4
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               in_valid,
   input  logic [3:0]                         in,
   input  logic                               flush,
   output logic                               in_ready,
   output logic                               out_valid,
   output logic [4*NIBBLES-1:0]               out,
   output logic [$clog2(NIBBLES+1)-1:0]       out_cnt,
   input  logic                               out_ready
);

   localparam int W  = 4 * NIBBLES;
   localparam int CW = $clog2(NIBBLES + 1);
   localparam int FW = $clog2(NIBBLES);

   logic [W-1:0]  r_acc;
   logic [FW-1:0] r_fill;
   logic [W-1:0]  r_data [0:1];
   logic [CW-1:0] r_cnt  [0:1];
   logic          r_rd;
   logic          r_wr;
   logic [1:0]    r_num;

   logic          w_acc_ok;
   logic          w_flush_ok;
   logic          w_full;
   logic          w_push;
   logic          w_pop;
   logic [W-1:0]  w_acc_nxt;
   logic [CW-1:0] w_fill_inc;
   logic [CW-1:0] w_push_cnt;

   // Depends on registers only, so no path from out_ready.
   assign in_ready   = (r_num != 2'd2);
   assign w_acc_ok   = in_valid & in_ready;
   assign w_flush_ok = flush & in_ready;
   assign w_full     = w_acc_ok && (r_fill == FW'(NIBBLES - 1));
   assign w_fill_inc = CW'(r_fill) + CW'(w_acc_ok);
   assign w_push     = w_full || (w_flush_ok && (w_fill_inc != '0));
   assign w_push_cnt = w_full ? CW'(NIBBLES) : w_fill_inc;
   assign w_pop      = out_valid & out_ready;

   // Unused upper slots are already zero because the
   // accumulator clears on every push.
   always_comb begin
      w_acc_nxt = r_acc;
      for (int k = 0; k < NIBBLES; k++) begin
         if (w_acc_ok && (r_fill == FW'(k)))
            w_acc_nxt[4*k +: 4] = in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc  <= '0;
         r_fill <= '0;
      end else if (w_push) begin
         r_acc  <= '0;
         r_fill <= '0;
      end else begin
         r_acc <= w_acc_nxt;
         if (w_acc_ok)
            r_fill <= r_fill + FW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data[0] <= '0;
         r_data[1] <= '0;
         r_cnt[0]  <= '0;
         r_cnt[1]  <= '0;
         r_rd      <= 1'b0;
         r_wr      <= 1'b0;
         r_num     <= 2'd0;
      end else begin
         if (w_push) begin
            r_data[r_wr] <= w_acc_nxt;
            r_cnt[r_wr]  <= w_push_cnt;
            r_wr         <= ~r_wr;
         end
         if (w_pop)
            r_rd <= ~r_rd;
         r_num <= r_num + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   assign out_valid = (r_num != 2'd0);
   assign out       = out_valid ? r_data[r_rd] : '0;
   assign out_cnt   = out_valid ? r_cnt[r_rd] : '0;

endmodule

// File: tb/tb_rot_nibble_packer.sv
// Directed-vector bench for rot_nibble_packer (NIBBLES=4).
// Inputs change 1ns after each rising edge; outputs checked there.
module tb_rot_nibble_packer;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [3:0]  d_in;
   logic        flush;
   logic        in_ready;
   logic        out_valid;
   logic [15:0] d_out;
   logic [2:0]  out_cnt;
   logic        out_ready;

   int n_chk;
   int n_pass;

   rot_nibble_packer #(.NIBBLES(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in        (d_in),
      .flush     (flush),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out       (d_out),
      .out_cnt   (out_cnt),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_word(input string tag,
                           input logic [15:0] w,
                           input logic [2:0] c);
      check({tag, ".valid"}, 32'(out_valid), 32'd1);
      check({tag, ".out"}, 32'(d_out), 32'(w));
      check({tag, ".cnt"}, 32'(out_cnt), 32'(c));
   endtask

   initial begin
      n_chk     = 0;
      n_pass    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      d_in      = 4'h0;
      flush     = 1'b0;
      out_ready = 1'b1;
      #12;
      check("rst.valid", 32'(out_valid), 32'd0);
      check("rst.out", 32'(d_out), 32'd0);
      check("rst.cnt", 32'(out_cnt), 32'd0);
      check("rst.ready", 32'(in_ready), 32'd1);

      // stream 1..4, first nibble on first edge after release
      rst_n    = 1'b1;
      in_valid = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         d_in = 4'(i);
         cyc();
         if (i < 4)
            check("s1.early", 32'(out_valid), 32'd0);
      end
      in_valid = 1'b0;
      chk_word("s1", 16'h4321, 3'd4);
      cyc();
      check("s1.one", 32'(out_valid), 32'd0);

      // back-to-back 1..8
      in_valid = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         d_in = 4'(i);
         cyc();
         check("b2b.rdy", 32'(in_ready), 32'd1);
         if (i == 4) chk_word("b2b.w0", 16'h4321, 3'd4);
         if (i == 5) check("b2b.gap", 32'(out_valid), 32'd0);
         if (i == 8) chk_word("b2b.w1", 16'h8765, 3'd4);
      end
      in_valid = 1'b0;
      cyc();

      // backpressure: two words buffered, nibble 9 held
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         d_in = 4'(i);
         cyc();
      end
      check("bp.full", 32'(in_ready), 32'd0);
      chk_word("bp.h0", 16'h4321, 3'd4);
      d_in = 4'h9;
      cyc();
      cyc();
      check("bp.hold", 32'(in_ready), 32'd0);
      chk_word("bp.h0b", 16'h4321, 3'd4);
      out_ready = 1'b1;
      cyc();
      chk_word("bp.h1", 16'h8765, 3'd4);
      check("bp.rdy", 32'(in_ready), 32'd1);
      cyc();
      check("bp.empty", 32'(out_valid), 32'd0);
      in_valid = 1'b0;
      flush    = 1'b1;
      cyc();
      chk_word("bp.nine", 16'h0009, 3'd1);
      flush = 1'b0;
      cyc();
      check("bp.done", 32'(out_valid), 32'd0);

      // flush alone, empty flush, flush with nibble
      in_valid = 1'b1;
      d_in = 4'hA; cyc();
      d_in = 4'hB; cyc();
      in_valid = 1'b0;
      flush    = 1'b1;
      cyc();
      chk_word("fl.ab", 16'h00BA, 3'd2);
      cyc();
      check("fl.empty", 32'(out_valid), 32'd0);
      flush    = 1'b0;
      in_valid = 1'b1;
      d_in = 4'hA; cyc();
      d_in = 4'hB; cyc();
      d_in  = 4'hC;
      flush = 1'b1;
      cyc();
      chk_word("fl.abc", 16'h0CBA, 3'd3);
      flush    = 1'b0;
      in_valid = 1'b0;
      cyc();
      check("fl.done", 32'(out_valid), 32'd0);

      // flush coincident with word completion
      in_valid = 1'b1;
      d_in = 4'h5; cyc();
      d_in = 4'h6; cyc();
      d_in = 4'h7; cyc();
      d_in  = 4'h8;
      flush = 1'b1;
      cyc();
      chk_word("fc.w", 16'h8765, 3'd4);
      flush    = 1'b0;
      in_valid = 1'b0;
      cyc();
      check("fc.none", 32'(out_valid), 32'd0);
      cyc();
      check("fc.none2", 32'(out_valid), 32'd0);

      // async reset mid-word with a word pending
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         d_in = 4'(i);
         cyc();
      end
      chk_word("ar.pend", 16'h4321, 3'd4);
      in_valid = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      check("ar.valid", 32'(out_valid), 32'd0);
      check("ar.out", 32'(d_out), 32'd0);
      check("ar.cnt", 32'(out_cnt), 32'd0);
      check("ar.rdy", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      rst_n     = 1'b1;
      in_valid  = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         d_in = 4'(i);
         cyc();
      end
      in_valid = 1'b0;
      chk_word("ar.w", 16'h4321, 3'd4);
      cyc();
      check("ar.done", 32'(out_valid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
